// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one imem request per PC value, holds the returned
// word for decode, and drives the PC hold (pc_stall) and program-finish signals.
// Optional build macro: FETCH_MISALIGN_CHECK_EN -- a misaligned PC halts with
// fetch_err instead of being silently aligned.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] END_INSTR = 32'h00000073,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       pc,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              id_ready,
  output logic              finish_flag,
  output logic              fetch_err
);

  localparam logic [31:0] PcPreStart = 32'hFFFFFFFC;
  localparam int unsigned CntW       = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StHalt} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              finish_q, finish_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = |pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Next-state logic plus the combinational PC hold.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = 1'b0;
    imem_addr_d = imem_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    finish_d    = finish_q;
    err_d       = err_q;
    cnt_d       = '0;
    pc_stall    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pc == PcPreStart) begin
          // Let the PC step from its pre-start value to 0.
          pc_stall = 1'b0;
        end else if (misalign) begin
          err_d    = 1'b1;
          finish_d = 1'b1;
          state_d  = StHalt;
        end else begin
          addr_d      = pc;
          imem_addr_d = {pc[ADDR_W-1:2], 2'b00};
          req_d       = 1'b1;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = addr_q;
          valid_d    = 1'b1;
          state_d    = StHold;
        end else begin
          cnt_d   = CntW'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = addr_q;
          valid_d    = 1'b1;
          state_d    = StHold;
        end else if (cnt_q >= TimeoutCnt) begin
          err_d    = 1'b1;
          finish_d = 1'b1;
          state_d  = StHalt;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (id_ready) begin
          valid_d = 1'b0;
          if (instr_q == END_INSTR) begin
            finish_d = 1'b1;
            state_d  = StHalt;
          end else begin
            pc_stall = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      req_q       <= 1'b0;
      imem_addr_q <= '0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      valid_q     <= 1'b0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      valid_q     <= valid_d;
      finish_q    <= finish_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign finish_flag = finish_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of per-cycle vectors for the main
// fetch flow, then hand-written sequences for timeout, late response, mid-fetch
// reset and misaligned PC handling.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        id_ready;
  logic        finish_flag;
  logic        fetch_err;

  int n_vec  = 0;
  int n_miss = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc          (pc),
    .pc_stall    (pc_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .id_ready    (id_ready),
    .finish_flag (finish_flag),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {pc_stall, imem_req, instr_valid, finish_flag, fetch_err}
  typedef struct {
    logic        rst_n;
    logic [31:0] pc;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic [4:0]  flags;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic r, logic [31:0] p, logic rv, logic [31:0] rd, logic rdy,
                              logic [4:0] f, logic [31:0] a, logic [31:0] in,
                              logic [31:0] ip);
    vec_t v;
    v.rst_n = r; v.pc = p; v.rvalid = rv; v.rdata = rd; v.rdy = rdy;
    v.flags = f; v.addr = a; v.instr = in; v.ipc = ip;
    return v;
  endfunction

  function automatic logic [127:0] outs();
    return {27'd0, pc_stall, imem_req, instr_valid, finish_flag, fetch_err,
            imem_addr, instr, instr_pc};
  endfunction

  function automatic logic [127:0] expo(logic [4:0] f, logic [31:0] a, logic [31:0] in,
                                        logic [31:0] ip);
    return {27'd0, f, a, in, ip};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    pc          = 32'hFFFFFFFC;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    id_ready    = 1'b0;

    //            rst pc            rv rdata         rdy flags     addr   instr         ipc
    tbl[0]  = mk(0, 32'hFFFFFFFC, 0, 0,            0, 5'b00000, 0,     0,            0);
    tbl[1]  = mk(1, 32'hFFFFFFFC, 0, 0,            0, 5'b00000, 0,     0,            0);
    tbl[2]  = mk(1, 32'h0,        0, 0,            0, 5'b10000, 0,     0,            0);
    tbl[3]  = mk(1, 32'h0,        1, 32'h00500093, 0, 5'b11000, 0,     0,            0);
    tbl[4]  = mk(1, 32'h0,        0, 0,            1, 5'b00100, 0,     32'h00500093, 0);
    tbl[5]  = mk(1, 32'h4,        0, 0,            0, 5'b10000, 0,     32'h00500093, 0);
    tbl[6]  = mk(1, 32'h4,        0, 0,            0, 5'b11000, 32'h4, 32'h00500093, 0);
    tbl[7]  = mk(1, 32'h4,        0, 0,            0, 5'b10000, 32'h4, 32'h00500093, 0);
    tbl[8]  = mk(1, 32'h4,        0, 0,            0, 5'b10000, 32'h4, 32'h00500093, 0);
    tbl[9]  = mk(1, 32'h4,        1, 32'h00A00113, 0, 5'b10000, 32'h4, 32'h00500093, 0);
    for (int i = 10; i < 15; i++)
      tbl[i] = mk(1, 32'h4,       0, 0,            0, 5'b10100, 32'h4, 32'h00A00113, 32'h4);
    tbl[15] = mk(1, 32'h4,        0, 0,            1, 5'b00100, 32'h4, 32'h00A00113, 32'h4);
    tbl[16] = mk(1, 32'h8,        0, 0,            0, 5'b10000, 32'h4, 32'h00A00113, 32'h4);
    tbl[17] = mk(1, 32'h8,        1, 32'h00000073, 0, 5'b11000, 32'h8, 32'h00A00113, 32'h4);
    tbl[18] = mk(1, 32'h8,        0, 0,            1, 5'b10100, 32'h8, 32'h00000073, 32'h8);
    tbl[19] = mk(1, 32'h8,        1, 32'hDEADBEEF, 1, 5'b10010, 32'h8, 32'h00000073, 32'h8);
    tbl[20] = mk(1, 32'h8,        0, 0,            0, 5'b10010, 32'h8, 32'h00000073, 32'h8);
    tbl[21] = mk(0, 32'hFFFFFFFC, 0, 0,            0, 5'b00000, 0,     0,            0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      reset_n     = tbl[i].rst_n;
      pc          = tbl[i].pc;
      imem_rvalid = tbl[i].rvalid;
      imem_rdata  = tbl[i].rdata;
      id_ready    = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), outs(),
          expo(tbl[i].flags, tbl[i].addr, tbl[i].instr, tbl[i].ipc));
    end

    // Timeout: 16 WAIT cycles without a response, then halt with fetch_err.
    @(negedge clk);
    reset_n = 1'b1; pc = 32'h0; imem_rvalid = 1'b0; id_ready = 1'b0;
    @(negedge clk); #1;
    chk("to_req", outs(), expo(5'b11000, 0, 0, 0));
    repeat (16) @(negedge clk);
    #1;
    chk("to_last_wait", outs(), expo(5'b10000, 0, 0, 0));
    @(negedge clk); #1;
    chk("to_halt", outs(), expo(5'b10011, 0, 0, 0));
    imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
    repeat (3) @(negedge clk);
    #1;
    chk("to_late_rvalid", outs(), expo(5'b10011, 0, 0, 0));

    // Response arriving in the final WAIT cycle beats the timeout.
    @(negedge clk);
    reset_n = 1'b0; imem_rvalid = 1'b0; pc = 32'h0;
    #1;
    chk("rst_async", outs(), expo(5'b10000, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    repeat (16) @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'h00100013;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("rv_priority", outs(), expo(5'b10100, 0, 32'h00100013, 0));

    // Accept, refetch at 0x10, then reset mid-WAIT.
    id_ready = 1'b1;
    #1;
    chk("hold_release", outs(), expo(5'b00100, 0, 32'h00100013, 0));
    @(negedge clk);
    id_ready = 1'b0; pc = 32'h10;
    @(negedge clk); #1;
    chk("req_0x10", outs(), expo(5'b11000, 32'h10, 32'h00100013, 0));
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_mid_wait", outs(), expo(5'b10000, 0, 0, 0));
    pc = 32'hFFFFFFFC; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("stale_rvalid", outs(), expo(5'b00000, 0, 0, 0));

    // Misaligned PC.
    @(negedge clk);
    reset_n = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; pc = 32'h6;
    @(negedge clk); #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_halt", outs(), expo(5'b10011, 0, 0, 0));
`else
    chk("misalign_req", outs(), expo(5'b11000, 32'h4, 0, 0));
    imem_rvalid = 1'b1; imem_rdata = 32'h00000013;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("misalign_hold", outs(), expo(5'b10100, 32'h4, 32'h00000013, 32'h6));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
